spi_rx_slave: RTL and testbench

Receive-side SPI endpoint that sits directly downstream of the team's 12-bit SPI transmitter, on the same `clk` domain. It consumes `cs`, `sclk` and `mosi` and synchronizes them to `clk`. It deserializes one LSB-first word per chip-select frame and presents each word on a valid/ready output port. Short, long and dropped frames are flagged rather than delivered.

---
 rtl/spi_rx_slave.sv | 130 +++++++++++++
 tb/tb_spi_rx_slave.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_slave.sv
// SPI receive endpoint: synchronizes cs/sclk/mosi to clk, deserializes one
// LSB-first word per chip-select frame and offers it on a valid/ready port.
module spi_rx_slave #(
    parameter int WIDTH       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             sclk,
    input  logic             mosi,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);
    localparam logic [CW-1:0] SAT  = CW'(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RECV, EMIT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES:0]   warm;
    logic                   cs_q;
    logic                   sclk_q;
    logic                   armed;
    logic [WIDTH-1:0]       shreg;
    logic [CW-1:0]          bitcnt;

    logic cs_s, sclk_s, mosi_s;
    logic sclk_rise, cs_fall, cs_rise;

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign cs_fall   = ~cs_s & cs_q;
    assign cs_rise   = cs_s & ~cs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_q      <= cs_s;
            sclk_q    <= sclk_s;
        end
    end

    // The synchronizer reset values are not real samples; only once the
    // pipeline has flushed and cs is seen high is a cs fall trusted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm  <= '0;
            armed <= 1'b0;
        end else begin
            warm <= {warm[SYNC_STAGES-1:0], 1'b1};
            if (warm[SYNC_STAGES] && cs_s && cs_q)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (dout_valid && dout_ready)
                dout_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (cs_fall && armed) begin
                        state  <= RECV;
                        busy   <= 1'b1;
                        shreg  <= '0;
                        bitcnt <= '0;
                    end
                end
                RECV: begin
                    if (sclk_rise) begin
                        if (bitcnt < FULL)
                            shreg <= shreg | (WIDTH'(mosi_s) << bitcnt);
                        if (bitcnt != SAT)
                            bitcnt <= bitcnt + CW'(1);
                    end
                    if (cs_rise) begin
                        state <= EMIT;
                        busy  <= 1'b0;
                    end
                end
                EMIT: begin
                    state <= IDLE;
                    // A stalled consumer keeps its word; the new one is lost.
                    if (bitcnt != FULL) begin
                        frame_err <= 1'b1;
                    end else if (!dout_valid || dout_ready) begin
                        dout       <= shreg;
                        dout_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rx_slave.sv
// Directed and randomized frames for spi_rx_slave, checked against a
// frame-level model of the delivered word and the valid/error/overrun outcome.
module tb_spi_rx_slave;

    localparam int WIDTH = 12;
    localparam int HALF  = 11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cs = 1'b1;
    logic             sclk = 1'b0;
    logic             mosi = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready = 1'b0;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] m_dout  = '0;
    logic             m_valid = 1'b0;

    spi_rx_slave #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setReady(input logic v);
        dout_ready = v;
        @(negedge clk);
        if (v && m_valid)
            m_valid = 1'b0;
    endtask

    // Drives one transmitter frame; optionally pulses reset after rst_at bits.
    task automatic applyStimulus(input logic [WIDTH-1:0] data, input int nbits,
                                 input bit collide, input int rst_at);
        cs   = 1'b0;
        mosi = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < WIDTH) ? data[i] : 1'($urandom);
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            if (collide && i == nbits - 1) begin
                cs = 1'b1;
            end else begin
                repeat (HALF) @(negedge clk);
                sclk = 1'b0;
            end
            if (i == rst_at - 1) begin
                rst = 1'b1;
                #1;
                checkOutput("async reset dout", dout, 0);
                checkOutput("async reset valid", dout_valid, 0);
                checkOutput("async reset busy", busy, 0);
                m_valid = 1'b0;
                m_dout  = '0;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        if (!collide) begin
            repeat (HALF) @(negedge clk);
            cs = 1'b1;
        end
    endtask

    task automatic runFrame(input string tag, input logic [WIDTH-1:0] data, input int nbits,
                            input bit collide, input bit emit_ready, input int rst_at);
        bit   accepted;
        logic exp_err;
        logic exp_ovr;
        accepted = (rst_at < 0);
        applyStimulus(data, nbits, collide, rst_at);
        @(negedge clk);
        @(negedge clk);
        checkOutput({tag, " busy in frame"}, busy, accepted);
        @(negedge clk);
        checkOutput({tag, " busy at emit"}, busy, 0);
        checkOutput({tag, " valid before emit"}, dout_valid, m_valid);
        checkOutput({tag, " err before emit"}, frame_err, 0);
        if (emit_ready)
            dout_ready = 1'b1;
        exp_err = 1'b0;
        exp_ovr = 1'b0;
        if (accepted && nbits != WIDTH) begin
            exp_err = 1'b1;
            if (dout_ready && m_valid)
                m_valid = 1'b0;
        end else if (accepted) begin
            if (!m_valid || dout_ready) begin
                m_dout  = data;
                m_valid = 1'b1;
            end else begin
                exp_ovr = 1'b1;
            end
        end else if (dout_ready && m_valid) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        if (emit_ready)
            dout_ready = 1'b0;
        checkOutput({tag, " dout"}, dout, m_dout);
        checkOutput({tag, " valid"}, dout_valid, m_valid);
        checkOutput({tag, " frame_err"}, frame_err, exp_err);
        checkOutput({tag, " overrun"}, overrun, exp_ovr);
        if (dout_ready && m_valid)
            m_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, " valid after"}, dout_valid, m_valid);
        checkOutput({tag, " frame_err after"}, frame_err, 0);
        checkOutput({tag, " overrun after"}, overrun, 0);
        if (collide)
            sclk = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    initial begin
        int         sel;
        logic [WIDTH-1:0] rdata;
        int         rbits;
        logic       rrdy;
        bit         rcol;

        @(negedge clk);
        checkOutput("reset dout", dout, 0);
        checkOutput("reset valid", dout_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset frame_err", frame_err, 0);
        checkOutput("reset overrun", overrun, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        setReady(1'b1);
        runFrame("single", 12'hA5C, WIDTH, 1'b0, 1'b0, -1);

        setReady(1'b0);
        runFrame("stall first", 12'h123, WIDTH, 1'b0, 1'b0, -1);
        runFrame("stall second", 12'hFED, WIDTH, 1'b0, 1'b0, -1);
        setReady(1'b1);
        checkOutput("stall drain valid", dout_valid, 0);
        checkOutput("stall drain dout", dout, 12'h123);

        setReady(1'b0);
        runFrame("hold 001", 12'h001, WIDTH, 1'b0, 1'b0, -1);
        runFrame("emit ready 002", 12'h002, WIDTH, 1'b0, 1'b1, -1);

        runFrame("short", 12'h3C3, WIDTH - 1, 1'b0, 1'b0, -1);
        runFrame("long", 12'h0F0, WIDTH + 1, 1'b0, 1'b0, -1);

        runFrame("reset mid", 12'h5A5, WIDTH, 1'b0, 1'b0, 6);
        runFrame("after reset", 12'h7E1, WIDTH, 1'b0, 1'b0, -1);

        setReady(1'b1);
        runFrame("collision", 12'h5A3, WIDTH, 1'b1, 1'b0, -1);

        for (int k = 0; k < 10; k++) begin
            sel   = $urandom_range(0, 4);
            rbits = (sel == 0) ? WIDTH - 1 : (sel == 4) ? WIDTH + 1 : WIDTH;
            rdata = WIDTH'($urandom);
            rrdy  = 1'($urandom);
            rcol  = 1'($urandom);
            setReady(rrdy);
            runFrame($sformatf("random %0d", k), rdata, rbits, rcol, 1'b0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
